// File: rtl/r5p_tcb_arbiter_if.sv
// TCB request/response bundle: manager drives the request, subordinate drives rdy and the delayed response.
// Modports: master = request issuer, slave = request receiver.
interface r5p_tcb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int BEN  = XLEN/8
);
  logic            vld;
  logic            wen;
  logic [XLEN-1:0] adr;
  logic [BEN-1:0]  ben;
  logic [XLEN-1:0] wdt;
  logic            rdy;
  logic [XLEN-1:0] rdt;
  logic            err;

  modport master (output vld, wen, adr, ben, wdt, input  rdy, rdt, err);
  modport slave  (input  vld, wen, adr, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/r5p_tcb_arbiter.sv
// 2:1 TCB arbiter (IFU=m0, LSU=m1) onto one memory port; combinational grant, responses routed DLY cycles after transfer.
// Backpressure: s.rdy passes combinationally to the granted manager; a stalled grant is locked until it transfers.
module r5p_tcb_arbiter #(
  parameter int XLEN = 32,
  parameter int BEN  = XLEN/8,
  parameter int DLY  = 1,
  parameter bit RR   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  r5p_tcb_arbiter_if.slave     m0,
  r5p_tcb_arbiter_if.slave     m1,
  r5p_tcb_arbiter_if.master    s
);

  if (DLY < 1 || BEN != XLEN/8) begin : g_param_check
    $error("r5p_tcb_arbiter: DLY must be >= 1 and BEN must equal XLEN/8");
  end

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t         state, state_nxt;
  logic           lid, lid_nxt;
  logic           ptr;
  logic           gnt;
  logic           trn;
  logic [DLY-1:0] pipe_vld;
  logic [DLY-1:0] pipe_id;
  logic           rsp_vld;
  logic           rsp_id;

  always_comb begin
    gnt = 1'b0;
    if (state == ST_LOCKED)
      gnt = lid;
    else if (m0.vld && m1.vld)
      gnt = RR ? ~ptr : 1'b1;
    else
      gnt = m1.vld;
  end

  assign s.vld = m0.vld | m1.vld;
  assign s.wen = gnt ? m1.wen : m0.wen;
  assign s.adr = gnt ? m1.adr : m0.adr;
  assign s.ben = gnt ? m1.ben : m0.ben;
  assign s.wdt = gnt ? m1.wdt : m0.wdt;

  assign trn   = s.vld & s.rdy;
  assign m0.rdy = s.rdy & ~gnt & m0.vld;
  assign m1.rdy = s.rdy &  gnt & m1.vld;

  // Lock keeps the request stable towards the subordinate while it stalls.
  always_comb begin
    state_nxt = state;
    lid_nxt   = lid;
    case (state)
      ST_OPEN: begin
        if (s.vld && !s.rdy) begin
          state_nxt = ST_LOCKED;
          lid_nxt   = gnt;
        end
      end
      ST_LOCKED: begin
        if (trn)
          state_nxt = ST_OPEN;
      end
      default: state_nxt = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_OPEN;
      lid      <= 1'b0;
      ptr      <= 1'b1;
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      state <= state_nxt;
      lid   <= lid_nxt;
      if (trn)
        ptr <= gnt;
      pipe_vld[0] <= trn & ~s.wen;
      pipe_id[0]  <= gnt;
      for (int i = 1; i < DLY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign rsp_vld = pipe_vld[DLY-1];
  assign rsp_id  = pipe_id[DLY-1];

  assign m0.rdt = (rsp_vld && !rsp_id) ? s.rdt : {XLEN{1'b0}};
  assign m0.err = rsp_vld & ~rsp_id & s.err;
  assign m1.rdt = (rsp_vld &&  rsp_id) ? s.rdt : {XLEN{1'b0}};
  assign m1.err = rsp_vld &  rsp_id & s.err;

  lock_held_a: assert property (@(posedge clk) disable iff (!rst)
    (state == ST_LOCKED) |-> (lid ? m1.vld : m0.vld));

endmodule

// File: tb/tb_r5p_tcb_arbiter.sv
// Directed bench: instance a is round-robin with DLY=1, instance b is fixed-priority with DLY=3.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_r5p_tcb_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  r5p_tcb_arbiter_if #(.XLEN(32), .BEN(4)) a_m0 ();
  r5p_tcb_arbiter_if #(.XLEN(32), .BEN(4)) a_m1 ();
  r5p_tcb_arbiter_if #(.XLEN(32), .BEN(4)) a_s  ();
  r5p_tcb_arbiter_if #(.XLEN(32), .BEN(4)) b_m0 ();
  r5p_tcb_arbiter_if #(.XLEN(32), .BEN(4)) b_m1 ();
  r5p_tcb_arbiter_if #(.XLEN(32), .BEN(4)) b_s  ();

  r5p_tcb_arbiter #(.XLEN(32), .BEN(4), .DLY(1), .RR(1'b1)) u_a (
    .clk(clk), .rst(rst), .m0(a_m0), .m1(a_m1), .s(a_s)
  );

  r5p_tcb_arbiter #(.XLEN(32), .BEN(4), .DLY(3), .RR(1'b0)) u_b (
    .clk(clk), .rst(rst), .m0(b_m0), .m1(b_m1), .s(b_s)
  );

  task automatic clear_a();
    a_m0.vld = 0; a_m0.wen = 0; a_m0.adr = '0; a_m0.ben = 4'hF; a_m0.wdt = '0;
    a_m1.vld = 0; a_m1.wen = 0; a_m1.adr = '0; a_m1.ben = 4'hF; a_m1.wdt = '0;
    a_s.rdy = 0; a_s.rdt = '0; a_s.err = 0;
  endtask

  task automatic clear_b();
    b_m0.vld = 0; b_m0.wen = 0; b_m0.adr = '0; b_m0.ben = 4'hF; b_m0.wdt = '0;
    b_m1.vld = 0; b_m1.wen = 0; b_m1.adr = '0; b_m1.ben = 4'hF; b_m1.wdt = '0;
    b_s.rdy = 0; b_s.rdt = '0; b_s.err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_a();
    clear_b();
    repeat (2) @(negedge clk);
    a_s.rdt = 32'hFFFF_FFFF;
    a_s.err = 1'b1;
    #1;
    tests++; if (a_s.vld !== 1'b0) begin fails++; $display("FAIL reset_s_vld got=%0h exp=0", a_s.vld); end
    tests++; if (a_m0.rdy !== 1'b0) begin fails++; $display("FAIL reset_m0_rdy got=%0h exp=0", a_m0.rdy); end
    tests++; if (a_m1.rdy !== 1'b0) begin fails++; $display("FAIL reset_m1_rdy got=%0h exp=0", a_m1.rdy); end
    tests++; if (a_m0.rdt !== 32'h0) begin fails++; $display("FAIL reset_m0_rdt got=%0h exp=0", a_m0.rdt); end
    tests++; if (a_m1.rdt !== 32'h0) begin fails++; $display("FAIL reset_m1_rdt got=%0h exp=0", a_m1.rdt); end
    tests++; if (a_m0.err !== 1'b0) begin fails++; $display("FAIL reset_m0_err got=%0h exp=0", a_m0.err); end
    tests++; if (b_s.vld !== 1'b0) begin fails++; $display("FAIL reset_b_s_vld got=%0h exp=0", b_s.vld); end
    @(negedge clk);
    a_m1.vld = 1'b1;
    #1;
    tests++; if (a_s.vld !== 1'b1) begin fails++; $display("FAIL reset_s_vld_follows got=%0h exp=1", a_s.vld); end
    clear_a();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rr_alternate();
    logic        g;
    logic        pg;
    logic [31:0] rv;
    logic [31:0] exp_adr;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rv = 32'hD000_0000 + 32'(c);
      a_m0.vld = (c < 4); a_m0.wen = 1'b0; a_m0.adr = 32'h100;
      a_m1.vld = (c < 4); a_m1.wen = 1'b0; a_m1.adr = 32'h200;
      a_s.rdy = 1'b1;
      a_s.rdt = rv;
      #1;
      if (c < 4) begin
        g = c[0];
        exp_adr = g ? 32'h200 : 32'h100;
        tests++; if (a_s.adr !== exp_adr) begin fails++; $display("FAIL rr_adr c=%0d got=%0h exp=%0h", c, a_s.adr, exp_adr); end
        tests++; if (a_m0.rdy !== ~g) begin fails++; $display("FAIL rr_m0_rdy c=%0d got=%0h exp=%0h", c, a_m0.rdy, ~g); end
        tests++; if (a_m1.rdy !== g) begin fails++; $display("FAIL rr_m1_rdy c=%0d got=%0h exp=%0h", c, a_m1.rdy, g); end
      end
      if (c > 0) begin
        pg = ~c[0];
        tests++; if (a_m0.rdt !== (pg ? 32'h0 : rv)) begin fails++; $display("FAIL rr_m0_rdt c=%0d got=%0h exp=%0h", c, a_m0.rdt, (pg ? 32'h0 : rv)); end
        tests++; if (a_m1.rdt !== (pg ? rv : 32'h0)) begin fails++; $display("FAIL rr_m1_rdt c=%0d got=%0h exp=%0h", c, a_m1.rdt, (pg ? rv : 32'h0)); end
      end
    end
    @(negedge clk);
    clear_a();
  endtask

  task automatic test_stall_lock();
    // Single m0 transfer leaves ptr=0, so an unlocked arbiter would pick m1 next.
    a_m0.vld = 1'b1; a_m0.adr = 32'h500; a_s.rdy = 1'b1;
    #1;
    tests++; if (a_m0.rdy !== 1'b1) begin fails++; $display("FAIL stall_pre_m0_rdy got=%0h exp=1", a_m0.rdy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_m0.vld = 1'b1; a_m0.adr = 32'h300;
      a_m1.vld = (k >= 1); a_m1.adr = 32'h400;
      a_s.rdy = 1'b0;
      #1;
      tests++; if (a_s.adr !== 32'h300) begin fails++; $display("FAIL stall_adr k=%0d got=%0h exp=300", k, a_s.adr); end
      tests++; if (a_m0.rdy !== 1'b0 || a_m1.rdy !== 1'b0) begin fails++; $display("FAIL stall_rdy k=%0d got=%0h/%0h exp=0/0", k, a_m0.rdy, a_m1.rdy); end
    end
    @(negedge clk);
    a_s.rdy = 1'b1;
    #1;
    tests++; if (a_s.adr !== 32'h300) begin fails++; $display("FAIL stall_release_adr got=%0h exp=300", a_s.adr); end
    tests++; if (a_m0.rdy !== 1'b1 || a_m1.rdy !== 1'b0) begin fails++; $display("FAIL stall_release_rdy got=%0h/%0h exp=1/0", a_m0.rdy, a_m1.rdy); end
    @(negedge clk);
    a_m0.vld = 1'b0;
    #1;
    tests++; if (a_s.adr !== 32'h400) begin fails++; $display("FAIL stall_next_adr got=%0h exp=400", a_s.adr); end
    tests++; if (a_m1.rdy !== 1'b1) begin fails++; $display("FAIL stall_next_m1_rdy got=%0h exp=1", a_m1.rdy); end
    @(negedge clk);
    clear_a();
  endtask

  task automatic test_fixed_prio();
    logic g;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      g = (c != 2);
      b_s.rdy = 1'b1;
      b_m0.vld = 1'b1; b_m0.wen = 1'b1; b_m0.adr = 32'h10;
      b_m1.vld = g;    b_m1.wen = 1'b1; b_m1.adr = 32'h20;
      #1;
      tests++; if (b_s.adr !== (g ? 32'h20 : 32'h10)) begin fails++; $display("FAIL fp_adr c=%0d got=%0h exp=%0h", c, b_s.adr, (g ? 32'h20 : 32'h10)); end
      tests++; if (b_m0.rdy !== ~g || b_m1.rdy !== g) begin fails++; $display("FAIL fp_rdy c=%0d got=%0h/%0h exp=%0h/%0h", c, b_m0.rdy, b_m1.rdy, ~g, g); end
    end
    @(negedge clk);
    clear_b();
  endtask

  task automatic test_dly3_back_to_back();
    logic [31:0] rv;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      rv = 32'hB000_0000 + 32'(c);
      b_s.rdy = 1'b1;
      b_s.rdt = rv;
      b_s.err = (c == 5);
      b_m1.vld = (c == 0); b_m1.wen = 1'b1; b_m1.adr = 32'h600; b_m1.wdt = 32'h1234_5678;
      b_m0.vld = (c == 1 || c == 2); b_m0.wen = 1'b0;
      b_m0.adr = (c == 2) ? 32'h704 : 32'h700;
      #1;
      if (c == 0) begin
        tests++; if (b_s.wen !== 1'b1 || b_s.wdt !== 32'h1234_5678) begin fails++; $display("FAIL d3_write_fields got=%0h/%0h exp=1/12345678", b_s.wen, b_s.wdt); end
        tests++; if (b_m1.rdy !== 1'b1) begin fails++; $display("FAIL d3_write_rdy got=%0h exp=1", b_m1.rdy); end
      end
      if (c == 2 || c == 3 || c == 6) begin
        tests++; if (b_m0.rdt !== 32'h0 || b_m1.rdt !== 32'h0) begin fails++; $display("FAIL d3_idle_rdt c=%0d got=%0h/%0h exp=0/0", c, b_m0.rdt, b_m1.rdt); end
        tests++; if (b_m0.err !== 1'b0 || b_m1.err !== 1'b0) begin fails++; $display("FAIL d3_idle_err c=%0d got=%0h/%0h exp=0/0", c, b_m0.err, b_m1.err); end
      end
      if (c == 4 || c == 5) begin
        tests++; if (b_m0.rdt !== rv) begin fails++; $display("FAIL d3_m0_rdt c=%0d got=%0h exp=%0h", c, b_m0.rdt, rv); end
        tests++; if (b_m0.err !== (c == 5)) begin fails++; $display("FAIL d3_m0_err c=%0d got=%0h exp=%0h", c, b_m0.err, (c == 5)); end
        tests++; if (b_m1.rdt !== 32'h0 || b_m1.err !== 1'b0) begin fails++; $display("FAIL d3_m1_quiet c=%0d got=%0h/%0h exp=0/0", c, b_m1.rdt, b_m1.err); end
      end
    end
    @(negedge clk);
    clear_b();
  endtask

  task automatic test_reset_mid();
    a_m0.vld = 1'b1; a_m0.adr = 32'h800; a_s.rdy = 1'b1;
    #1;
    tests++; if (a_m0.rdy !== 1'b1) begin fails++; $display("FAIL rmid_pre_m0_rdy got=%0h exp=1", a_m0.rdy); end
    // m1 stalls alone, taking the lock; ptr is 0 from the m0 transfer.
    @(negedge clk);
    a_m0.vld = 1'b0;
    a_m1.vld = 1'b1; a_m1.adr = 32'h900;
    a_s.rdy = 1'b0;
    a_s.rdt = 32'hCAFE_0000;
    #1;
    tests++; if (a_s.adr !== 32'h900) begin fails++; $display("FAIL rmid_lock_adr got=%0h exp=900", a_s.adr); end
    tests++; if (a_m0.rdt !== 32'hCAFE_0000) begin fails++; $display("FAIL rmid_pre_rsp got=%0h exp=cafe0000", a_m0.rdt); end
    @(negedge clk);
    rst = 1'b0;
    a_s.rdt = '0;
    @(negedge clk);
    rst = 1'b1;
    a_m0.vld = 1'b1; a_m0.adr = 32'hA00;
    a_m1.vld = 1'b1; a_m1.adr = 32'hB00;
    a_s.rdy = 1'b1;
    #1;
    tests++; if (a_s.adr !== 32'hA00 || a_m0.rdy !== 1'b1) begin fails++; $display("FAIL rmid_post_gnt got=%0h/%0h exp=a00/1", a_s.adr, a_m0.rdy); end
    // Read to m0 is in flight; reset must discard it.
    @(negedge clk);
    rst = 1'b0;
    clear_a();
    a_s.rdt = 32'hCAFE_0001;
    a_s.err = 1'b1;
    #1;
    tests++; if (a_m0.rdt !== 32'h0 || a_m0.err !== 1'b0) begin fails++; $display("FAIL rmid_in_reset got=%0h/%0h exp=0/0", a_m0.rdt, a_m0.err); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (a_m0.rdt !== 32'h0 || a_m0.err !== 1'b0) begin fails++; $display("FAIL rmid_after_release got=%0h/%0h exp=0/0", a_m0.rdt, a_m0.err); end
    tests++; if (a_m1.rdt !== 32'h0 || a_m1.err !== 1'b0) begin fails++; $display("FAIL rmid_m1_after_release got=%0h/%0h exp=0/0", a_m1.rdt, a_m1.err); end
    @(negedge clk);
    clear_a();
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_stall_lock();
    test_fixed_prio();
    test_dly3_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
